// File: rtl/phy_tx_par2serial_if.sv
// Byte-side link between the lane-mux tree and the serializer.
// The master is the upstream byte source; the slave is the serializer.
interface phy_tx_par2serial_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       byte_req;
  logic       data_out;
  logic       active;

  modport master (
    output data_in,
    output valid_in,
    input  byte_req,
    input  data_out,
    input  active
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output byte_req,
    output data_out,
    output active
  );
endinterface

// File: rtl/phy_tx_par2serial.sv
// Final phy_tx stage: shifts bytes out MSB first on the bit clock, opening with a
// burst of COM alignment symbols and padding empty slots with IDLE.
module phy_tx_par2serial #(
  parameter logic [7:0] COM_SYM    = 8'hBC,
  parameter logic [7:0] IDLE_SYM   = 8'h7C,
  parameter int         SYNC_BYTES = 4
) (
  input  logic                  clk_32f,
  input  logic                  reset_L,
  phy_tx_par2serial_if.slave    bus
);

  localparam int SYNC_W = (SYNC_BYTES > 1) ? $clog2(SYNC_BYTES) : 1;
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_BYTES - 1);

  typedef enum logic {SYNC, ACTIVE} state_t;

  state_t            state_q;
  logic [2:0]        bitCnt_q;
  logic [SYNC_W-1:0] syncCnt_q;
  logic [7:0]        shReg_q;
  logic [7:0]        shReg_d;
  logic              dataOut_q;
  logic              active_q;
  logic              lastBit;
  logic              capture;

  // A byte is taken from upstream on the load edge of the last COM byte and
  // on every load edge afterwards; earlier load edges reload COM.
  assign lastBit = (bitCnt_q == 3'd7);
  assign capture = lastBit && ((state_q == ACTIVE) || (syncCnt_q == SYNC_LAST));

  always_comb begin
    shReg_d = {shReg_q[6:0], 1'b0};
    if (lastBit) begin
      if (capture) begin
        shReg_d = bus.valid_in ? bus.data_in : IDLE_SYM;
      end else begin
        shReg_d = COM_SYM;
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= SYNC;
      bitCnt_q  <= 3'd0;
      syncCnt_q <= '0;
      shReg_q   <= COM_SYM;
      dataOut_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      dataOut_q <= shReg_q[7];
      bitCnt_q  <= bitCnt_q + 3'd1;
      shReg_q   <= shReg_d;
      if (lastBit && (state_q == SYNC)) begin
        if (syncCnt_q == SYNC_LAST) begin
          state_q  <= ACTIVE;
          active_q <= 1'b1;
        end else begin
          syncCnt_q <= syncCnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.byte_req = capture;
  assign bus.data_out = dataOut_q;
  assign bus.active   = active_q;

endmodule

// File: tb/tb_phy_tx_par2serial.sv
// Directed bench for phy_tx_par2serial: one instance with four SYNC bytes and
// one with a single SYNC byte, checked bit by bit against hand-computed bytes.
module tb_phy_tx_par2serial;

  logic clk_32f = 1'b0;
  logic resetA_L;
  logic resetB_L;
  int   testCount = 0;
  int   failCount = 0;

  phy_tx_par2serial_if busA ();
  phy_tx_par2serial_if busB ();

  phy_tx_par2serial #(.SYNC_BYTES(4)) dutA (
    .clk_32f (clk_32f),
    .reset_L (resetA_L),
    .bus     (busA.slave)
  );

  phy_tx_par2serial #(.SYNC_BYTES(1)) dutB (
    .clk_32f (clk_32f),
    .reset_L (resetB_L),
    .bus     (busB.slave)
  );

  // Bit clock: rising edges at 5, 15, 25, ...
  always #5 clk_32f = ~clk_32f;

  // One comparison: counts it, and counts and reports it when it misses.
  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic driveInputs(input logic v, input logic [7:0] d);
    busA.valid_in = v;
    busA.data_in  = d;
    busB.valid_in = v;
    busB.data_in  = d;
  endtask

  // Runs nEdges bit-clock edges of one byte slot on the selected instance.
  // Inputs are random except in the cycle before the slot's last edge, where
  // the load values are held; byte_req is checked before each edge, data_out
  // after each edge, and active after a complete slot.
  task automatic applyStimulus(input bit useB, input string tag,
                               input logic [7:0] expByte, input int nEdges,
                               input bit expReq, input logic loadValid,
                               input logic [7:0] loadData, input bit expActive);
    logic [2:0] idx;
    for (int i = 0; i < nEdges; i++) begin
      if (i == 7) driveInputs(loadValid, loadData);
      else        driveInputs(1'($urandom_range(0, 1)), 8'($urandom));
      #1;
      checkOutput($sformatf("%s byte_req before bit%0d", tag, i),
                  useB ? busB.byte_req : busA.byte_req, expReq && (i == 7));
      @(posedge clk_32f);
      #1;
      idx = 3'(7 - i);
      checkOutput($sformatf("%s data_out bit%0d", tag, i),
                  useB ? busB.data_out : busA.data_out, expByte[idx]);
    end
    if (nEdges == 8) begin
      checkOutput($sformatf("%s active", tag),
                  useB ? busB.active : busA.active, expActive);
    end
  endtask

  initial begin
    resetA_L = 1'b0;
    resetB_L = 1'b0;
    driveInputs(1'b0, 8'h00);
    repeat (2) begin
      @(posedge clk_32f);
      #1;
    end

    // Both instances held in reset
    checkOutput("reset A data_out", busA.data_out, 1'b0);
    checkOutput("reset A active",   busA.active,   1'b0);
    checkOutput("reset A byte_req", busA.byte_req, 1'b0);
    checkOutput("reset B data_out", busB.data_out, 1'b0);
    checkOutput("reset B byte_req", busB.byte_req, 1'b0);

    // Four COM bytes, then A5, 01, two IDLE slots, 3C
    resetA_L = 1'b1;
    applyStimulus(1'b0, "A sync0", 8'hBC, 8, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, "A sync1", 8'hBC, 8, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, "A sync2", 8'hBC, 8, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, "A sync3", 8'hBC, 8, 1'b1, 1'b1, 8'hA5, 1'b1);
    applyStimulus(1'b0, "A A5",    8'hA5, 8, 1'b1, 1'b1, 8'h01, 1'b1);
    applyStimulus(1'b0, "A 01",    8'h01, 8, 1'b1, 1'b0, 8'hFF, 1'b1);
    applyStimulus(1'b0, "A idle0", 8'h7C, 8, 1'b1, 1'b0, 8'h3C, 1'b1);
    applyStimulus(1'b0, "A idle1", 8'h7C, 8, 1'b1, 1'b1, 8'h3C, 1'b1);
    applyStimulus(1'b0, "A 3C",    8'h3C, 8, 1'b1, 1'b1, 8'hE7, 1'b1);

    // Three bits of E7 (1,1,1) go out, then reset lands mid-byte
    applyStimulus(1'b0, "A E7 partial", 8'hE7, 3, 1'b1, 1'b0, 8'h00, 1'b1);
    resetA_L = 1'b0;
    #1;
    checkOutput("midreset A data_out", busA.data_out, 1'b0);
    checkOutput("midreset A active",   busA.active,   1'b0);
    checkOutput("midreset A byte_req", busA.byte_req, 1'b0);
    @(posedge clk_32f);
    #1;
    checkOutput("held reset A data_out", busA.data_out, 1'b0);
    checkOutput("held reset A active",   busA.active,   1'b0);

    // Full COM sequence again after release, then data
    resetA_L = 1'b1;
    applyStimulus(1'b0, "A2 sync0", 8'hBC, 8, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, "A2 sync1", 8'hBC, 8, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, "A2 sync2", 8'hBC, 8, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, "A2 sync3", 8'hBC, 8, 1'b1, 1'b1, 8'h5A, 1'b1);
    applyStimulus(1'b0, "A2 5A",    8'h5A, 8, 1'b1, 1'b0, 8'h00, 1'b1);

    // Single COM byte: first request before edge 8
    resetB_L = 1'b1;
    applyStimulus(1'b1, "B sync0", 8'hBC, 8, 1'b1, 1'b1, 8'h96, 1'b1);
    applyStimulus(1'b1, "B 96",    8'h96, 8, 1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, "B idle",  8'h7C, 8, 1'b1, 1'b1, 8'h42, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
